fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters (power of 2, 2..8).
REQ-002 SHALL have parameter DW, default 8, data width matching the FIFO write port.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port wclk  input  1  write-domain clock; all state on rising edge.
REQ-005 SHALL have port wrst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester data-valid.
REQ-007 SHALL have port req_data  input  NREQ*DW  packed data; requester i at bits [i*DW +: DW].
REQ-008 SHALL have port req_ready  output  NREQ  per-requester accept strobe.
REQ-009 SHALL have port wfull  input  1  FIFO full flag from write-side full logic.
REQ-010 SHALL have port wdata  output  DW  data to the FIFO write port.
REQ-011 SHALL have port winc  output  1  FIFO write strobe.
REQ-012 SHALL have port grant_id  output  log2(NREQ)  index of the currently granted requester.
REQ-013 SHALL have port busy  output  1  high while a grant is held.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, BURST.
REQ-015 In IDLE with any req_valid high: pick the first valid index scanning upward from rr_ptr, modulo NREQ; register it into grant_id; clear beat_cnt; go to BURST.
REQ-016 In IDLE: winc=0, req_ready=0; a one-cycle arbitration bubble precedes every grant.
REQ-017 In BURST: wdata = req_data slice of grant_id, combinationally.
REQ-018 In BURST: req_ready[grant_id] = !wfull; all other req_ready bits = 0.
REQ-019 In BURST: winc = req_valid[grant_id] & !wfull; a transfer is a cycle with winc=1.
REQ-020 winc SHALL never be 1 while wfull=1 or in IDLE.
REQ-021 On each transfer, beat_cnt SHALL increment by 1; it is wide enough for MAX_BURST without overflow.
REQ-022 BURST SHALL exit to IDLE after a transfer with beat_cnt == MAX_BURST-1 (burst limit).
REQ-023 BURST SHALL exit to IDLE in any cycle where req_valid[grant_id]=0 (requester drained).
REQ-024 While wfull=1 in BURST: hold state, grant_id and beat_cnt; no timeout.
REQ-025 On every BURST exit: rr_ptr = (grant_id+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-026 grant_id SHALL change only on the IDLE->BURST transition.
REQ-027 busy SHALL be 1 exactly when the state is BURST.
REQ-028 Requesters hold req_valid and req_data stable until accepted; the block does not buffer data.
REQ-029 Valid on non-granted requesters SHALL have no effect until the next IDLE arbitration.

Reset
REQ-030 wrst_n low SHALL immediately force: state IDLE, grant_id 0, rr_ptr 0, beat_cnt 0, winc 0, req_ready 0, busy 0.
REQ-031 A reset asserted mid-burst SHALL abandon the burst with no partial write on the reset edge.
REQ-032 After wrst_n deasserts, the first arbitration SHALL start from index 0.

Verification
REQ-033 Reset, then req_valid=4'b0001, data 0x11,0x22 -> grant_id=0 after 1 bubble cycle; two winc pulses with wdata 0x11, 0x22; IDLE when valid drops.
REQ-034 All four requesters continuously valid, MAX_BURST=4 -> grants 0,1,2,3,0 in order; exactly 4 writes each; 1 idle cycle between grants.
REQ-035 Requester 2 granted, wfull high for 5 cycles mid-burst -> winc=0 and req_ready=0 for those cycles; beat_cnt frozen; burst resumes; total 4 beats.
REQ-036 Requesters 1 and 3 valid, previous grant was 3 -> rr_ptr=0, so 1 is granted next, then 3.
REQ-037 wrst_n pulsed low during beat 2 of a burst -> outputs go to reset values asynchronously; the next grant starts scanning from index 0.
REQ-038 Random valid/wfull stress -> winc never high with wfull; data order per requester preserved; no requester starved beyond (NREQ-1)*(MAX_BURST+1) transfer slots.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that merges NREQ write requesters onto a
// single asynchronous-FIFO write port, granting each requester bursts of up
// to MAX_BURST beats.
//
// Handshake: a beat moves from requester i to the FIFO in a cycle where
// req_valid[i] and req_ready[i] are both high. This is the same cycle in which
// winc is high. The requester keeps req_valid/req_data stable until that cycle.
//
// Ports:
//   wclk, wrst_n  write-domain clock, asynchronous active-low reset
//   req_valid     per-requester data valid
//   req_data      packed requester data, requester i at [i*DW +: DW]
//   req_ready     per-requester accept strobe (only the granted bit can be high)
//   wfull         FIFO full flag; stalls the burst, never aborts it
//   wdata, winc   FIFO write port
//   grant_id      currently granted requester (changes only when a grant starts)
//   busy          high while a grant is held; this is the FSM state (BURST)
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wfull,
  output logic [DW-1:0]             wdata,
  output logic                      winc,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int GW = $clog2(NREQ);
  // One spare code so the counter can reach MAX_BURST without wrapping.
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [BW-1:0]   beat_cnt;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx;

  // Round-robin pick: scan offsets from highest to lowest so the lowest
  // offset from rr_ptr with a valid request wins. NREQ is a power of two,
  // so the GW-bit add wraps modulo NREQ for free.
  always_comb begin
    pick = rr_ptr;
    idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = rr_ptr + GW'(k);
      if (req_valid[idx]) pick = idx;
    end
  end

  assign busy  = (state == BURST);
  assign wdata = req_data[grant_id*DW +: DW];
  assign winc  = busy & req_valid[grant_id] & ~wfull;

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = ~wfull;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (!req_valid[grant_id]) begin
            // Requester drained: give up the grant even if the FIFO is full.
            state  <= IDLE;
            rr_ptr <= grant_id + 1'b1;
          end else if (!wfull) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state  <= IDLE;
              rr_ptr <= grant_id + 1'b1;
            end
          end
          // wfull with valid: hold everything, no timeout.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb (default parameters NREQ=4, DW=8, MAX_BURST=4).
// Inputs are driven on the falling edge and outputs sampled 1 ns later, well
// before the next rising edge.
module tb_fifo_wr_arb;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic [7:0]  wdata;
  logic        winc;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_wr_arb #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .wdata     (wdata),
    .winc      (winc),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         n_writes = 0;
  logic       sb_on = 1'b1;
  logic [5:0] seq[4];
  logic [5:0] exp_seq[4];
  logic [5:0] wr_cnt[4];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic        busy;
    logic        winc;
    logic [3:0]  ready;
    logic [1:0]  gid;
    logic [7:0]  wdata;
    logic        chk_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] r3, input logic [7:0] r2,
                                     input logic [7:0] r1, input logic [7:0] r0);
    return {r3, r2, r1, r0};
  endfunction

  task automatic add_vec(input logic [3:0] v, input logic [31:0] d, input logic f,
                         input logic b, input logic w, input logic [3:0] r,
                         input logic [1:0] g, input logic [7:0] wd, input logic cw);
    vec_t x;
    x.valid = v; x.data = d; x.full = f; x.busy = b; x.winc = w;
    x.ready = r; x.gid = g; x.wdata = wd; x.chk_wd = cw;
    vecs.push_back(x);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, then pop the scoreboard on any FIFO write.
  task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic f);
    logic [7:0] e;
    @(negedge wclk);
    req_valid = v;
    req_data  = d;
    wfull     = f;
    #1;
    if (sb_on && winc) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write: got wdata %0h, none expected (t=%0t)", wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_wdata", {24'h0, wdata}, {24'h0, e});
      end
    end
  endtask

  function automatic logic [31:0] seq_data();
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = {2'(i), seq[i]};
    return d;
  endfunction

  task automatic advance_seq();
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) seq[i] = seq[i] + 6'd1;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0]  sv;
    logic [31:0] d;
    logic        f;
    int          g;
    int          wait_cnt[4];
    int          max_wait;

    wrst_n = 1'b0; req_valid = '0; req_data = '0; wfull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = '0; exp_seq[i] = '0; wr_cnt[i] = '0; wait_cnt[i] = 0;
    end
    max_wait = 0;

    // Reset values, with a requester already valid to show reset dominates.
    @(negedge wclk);
    req_valid = 4'b0011;
    @(negedge wclk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_winc", winc, 0);
    check("rst_ready", req_ready, 0);
    check("rst_gid", grant_id, 0);
    req_valid = '0;
    @(negedge wclk);
    wrst_n = 1'b1;

    // ---- vector table ----
    // Single requester, two beats, then drained.
    add_vec(4'b0001, pk(0,0,0,8'h11), 0, 0,0,4'b0000,0, 8'h00,0);
    add_vec(4'b0001, pk(0,0,0,8'h11), 0, 1,1,4'b0001,0, 8'h11,0);
    add_vec(4'b0001, pk(0,0,0,8'h22), 0, 1,1,4'b0001,0, 8'h22,0);
    add_vec(4'b0000, 32'h0,           0, 1,0,4'b0001,0, 8'h00,1);
    add_vec(4'b0000, 32'h0,           0, 0,0,4'b0000,0, 8'h00,0);
    // Requester 2, five cycles of wfull after the first beat, four beats total.
    add_vec(4'b0100, pk(0,8'hA0,0,0), 0, 0,0,4'b0000,0, 8'h00,0);
    add_vec(4'b0100, pk(0,8'hA0,0,0), 0, 1,1,4'b0100,2, 8'hA0,0);
    for (int k = 0; k < 5; k++)
      add_vec(4'b0100, pk(0,8'hA1,0,0), 1, 1,0,4'b0000,2, 8'hA1,1);
    add_vec(4'b0100, pk(0,8'hA1,0,0), 0, 1,1,4'b0100,2, 8'hA1,0);
    add_vec(4'b0100, pk(0,8'hA2,0,0), 0, 1,1,4'b0100,2, 8'hA2,0);
    add_vec(4'b0100, pk(0,8'hA3,0,0), 0, 1,1,4'b0100,2, 8'hA3,0);
    add_vec(4'b0100, pk(0,8'hA4,0,0), 0, 0,0,4'b0000,2, 8'h00,0);
    add_vec(4'b0000, 32'h0,           0, 1,0,4'b0100,2, 8'h00,1);
    add_vec(4'b0000, 32'h0,           0, 0,0,4'b0000,2, 8'h00,0);
    // Grant 3, then 1 and 3 valid: pointer wrapped to 0, so 1 first, then 3.
    add_vec(4'b1000, pk(8'h33,0,0,0), 0, 0,0,4'b0000,2, 8'h00,0);
    add_vec(4'b1000, pk(8'h33,0,0,0), 0, 1,1,4'b1000,3, 8'h33,0);
    add_vec(4'b0000, 32'h0,           0, 1,0,4'b1000,3, 8'h00,0);
    add_vec(4'b1010, pk(8'h30,0,8'h10,0), 0, 0,0,4'b0000,3, 8'h00,0);
    add_vec(4'b1010, pk(8'h30,0,8'h10,0), 0, 1,1,4'b0010,1, 8'h10,0);
    add_vec(4'b1000, pk(8'h30,0,0,0), 0, 1,0,4'b0010,1, 8'h00,1);
    add_vec(4'b1000, pk(8'h30,0,0,0), 0, 0,0,4'b0000,1, 8'h00,0);
    add_vec(4'b1000, pk(8'h30,0,0,0), 0, 1,1,4'b1000,3, 8'h30,0);
    add_vec(4'b0000, 32'h0,           0, 1,0,4'b1000,3, 8'h00,0);
    add_vec(4'b0000, 32'h0,           0, 0,0,4'b0000,3, 8'h00,0);

    foreach (vecs[n]) begin
      if (vecs[n].winc) exp_q.push_back(vecs[n].wdata);
      apply(vecs[n].valid, vecs[n].data, vecs[n].full);
      check($sformatf("vec%0d_busy", n), busy, vecs[n].busy);
      check($sformatf("vec%0d_winc", n), winc, vecs[n].winc);
      check($sformatf("vec%0d_ready", n), req_ready, vecs[n].ready);
      check($sformatf("vec%0d_gid", n), grant_id, vecs[n].gid);
      if (vecs[n].chk_wd) check($sformatf("vec%0d_wdata", n), wdata, vecs[n].wdata);
    end

    // ---- all four valid: grants 0,1,2,3,0, four beats each, one bubble ----
    n_writes = 0;
    for (int c = 0; c < 25; c++) begin
      g = (c / 5) % 4;
      if (c % 5 != 0) begin
        exp_q.push_back({2'(g), wr_cnt[g]});
        wr_cnt[g] = wr_cnt[g] + 6'd1;
      end
      apply(4'hF, seq_data(), 1'b0);
      check("rr_busy", busy, c % 5 != 0);
      check("rr_winc", winc, c % 5 != 0);
      if (c % 5 != 0) check("rr_gid", grant_id, g);
      advance_seq();
    end
    apply(4'h0, 32'h0, 1'b0);
    check("rr_end_busy", busy, 0);
    check("rr_write_count", n_writes, 20);

    // ---- reset during beat 2 of a burst ----
    apply(4'b0100, pk(0,8'hC0,0,0), 1'b0);
    check("arst_pre_busy", busy, 0);
    exp_q.push_back(8'hC0);
    apply(4'b0100, pk(0,8'hC0,0,0), 1'b0);
    check("arst_b1_gid", grant_id, 2);
    exp_q.push_back(8'hC1);
    apply(4'b0100, pk(0,8'hC1,0,0), 1'b0);
    check("arst_b2_winc", winc, 1);
    #2;
    wrst_n = 1'b0;
    #1;
    check("arst_winc", winc, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", req_ready, 0);
    check("arst_gid", grant_id, 0);
    req_valid = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    apply(4'b1001, pk(8'hD3,0,0,8'hD0), 1'b0);
    check("arst_idle_busy", busy, 0);
    exp_q.push_back(8'hD0);
    apply(4'b1001, pk(8'hD3,0,0,8'hD0), 1'b0);
    check("arst_regrant_busy", busy, 1);
    check("arst_regrant_gid", grant_id, 0);
    apply(4'b0000, 32'h0, 1'b0);
    apply(4'b0000, 32'h0, 1'b0);
    check("sb_queue_empty", exp_q.size(), 0);

    // ---- random valid/wfull stress ----
    sb_on = 1'b0;
    sv = '0;
    for (int i = 0; i < 4; i++) begin seq[i] = '0; exp_seq[i] = '0; end
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++)
        if (!sv[i] && $urandom_range(0, 99) < 50) sv[i] = 1'b1;
      d = seq_data();
      f = ($urandom_range(0, 99) < 25);
      apply(sv, d, f);
      check("stress_no_write_when_full", winc & wfull, 0);
      check("stress_winc_handshake", winc, |(req_valid & req_ready));
      if (winc) begin
        check("stress_data_order", wdata, {grant_id, exp_seq[grant_id]});
        check("stress_ready_onehot", req_ready, 4'b0001 << grant_id);
        exp_seq[grant_id] = exp_seq[grant_id] + 6'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (winc && grant_id == 2'(i)) wait_cnt[i] = 0;
        else if (sv[i] && winc) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      for (int i = 0; i < 4; i++)
        if (sv[i] && req_ready[i]) begin
          seq[i] = seq[i] + 6'd1;
          sv[i]  = ($urandom_range(0, 99) < 70);
        end
    end
    check("stress_starvation_bound", max_wait <= 15, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
